// File: rtl/shift_sched_if.sv
// Request/response bundle between the two ALU-side requesters, the result
// consumer and the shift scheduler.
interface shift_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0;
    logic [2:0]  req_op1;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/shift_sched.sv
// Round-robin scheduler for one shared logical left/right shifter; builds
// SLL/SRL/SRA/ROTL/ROTR from one or two shifter passes.
module shift_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    shift_sched_if.slave     io_bus,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_sh_a,
    output logic [WIDTH-1:0] o_sh_b,
    output logic             o_sh_d,
    input  logic [WIDTH-1:0] i_sh_o
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_PASS1 = 2'b01;
    localparam logic [1:0] S_PASS2 = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROTL = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [4:0]       r_n;
    logic             r_id;
    logic [WIDTH-1:0] r_acc;
    logic             r_err;
    logic             r_last_gnt;
    logic             r_resp_valid;
    logic             r_busy;

    logic             w_gnt;
    logic             w_accept;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [4:0]       w_sel_n;
    logic [1:0]       w_state_nxt;
    logic [5:0]       w_inv_n;
    logic             w_unused_bits;

    function automatic logic f_legal(input logic [2:0] op);
        f_legal = (op <= OP_ROTR);
    endfunction

    function automatic logic f_need_pass2(input logic [2:0] op, input logic a_msb,
                                          input logic [4:0] n);
        f_need_pass2 = (n != 5'd0) &&
                       (((op == OP_SRA) && a_msb) || (op == OP_ROTL) || (op == OP_ROTR));
    endfunction

    function automatic logic f_pass1_dir(input logic [2:0] op);
        f_pass1_dir = (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROTR);
    endfunction

    assign w_unused_bits = ^{io_bus.req_b0[31:5], io_bus.req_b1[31:5]};
    assign w_inv_n       = 6'd32 - {1'b0, r_n};

    // Round-robin grant and operand selection; acceptance only while idle.
    always_comb begin
        if (io_bus.req_valid == 2'b11) begin
            w_gnt = ~r_last_gnt;
        end else if (io_bus.req_valid[0]) begin
            w_gnt = 1'b0;
        end else begin
            w_gnt = 1'b1;
        end
        w_accept = (r_state == S_IDLE) && (io_bus.req_valid != 2'b00);
        if (!w_accept) begin
            io_bus.req_ready = 2'b00;
        end else if (w_gnt) begin
            io_bus.req_ready = 2'b10;
        end else begin
            io_bus.req_ready = 2'b01;
        end
        if (w_gnt) begin
            w_sel_op = io_bus.req_op1;
            w_sel_a  = io_bus.req_a1;
            w_sel_n  = io_bus.req_b1[4:0];
        end else begin
            w_sel_op = io_bus.req_op0;
            w_sel_a  = io_bus.req_a0;
            w_sel_n  = io_bus.req_b0[4:0];
        end
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = f_legal(w_sel_op) ? S_PASS1 : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PASS1: begin
                if (f_need_pass2(r_op, r_a[WIDTH-1], r_n)) begin
                    w_state_nxt = S_PASS2;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_PASS2: w_state_nxt = S_DONE;
            S_DONE: begin
                if (io_bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shifter drive; the second pass supplies the bits the first pass shifted out.
    always_comb begin
        o_sh_a = {WIDTH{1'b0}};
        o_sh_b = {WIDTH{1'b0}};
        o_sh_d = 1'b0;
        case (r_state)
            S_PASS1: begin
                o_sh_a = r_a;
                o_sh_b = {{(WIDTH-5){1'b0}}, r_n};
                o_sh_d = f_pass1_dir(r_op);
            end
            S_PASS2: begin
                o_sh_b = {{(WIDTH-6){1'b0}}, w_inv_n};
                case (r_op)
                    OP_SRA: begin
                        o_sh_a = {WIDTH{1'b1}};
                        o_sh_d = 1'b0;
                    end
                    OP_ROTL: begin
                        o_sh_a = r_a;
                        o_sh_d = 1'b1;
                    end
                    OP_ROTR: begin
                        o_sh_a = r_a;
                        o_sh_d = 1'b0;
                    end
                    default: begin
                        o_sh_a = {WIDTH{1'b0}};
                        o_sh_d = 1'b0;
                    end
                endcase
            end
            default: begin
                o_sh_a = {WIDTH{1'b0}};
                o_sh_b = {WIDTH{1'b0}};
                o_sh_d = 1'b0;
            end
        endcase
    end

    // State, operand capture, accumulator and registered response flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 3'b000;
            r_a          <= {WIDTH{1'b0}};
            r_n          <= 5'd0;
            r_id         <= 1'b0;
            r_acc        <= {WIDTH{1'b0}};
            r_err        <= 1'b0;
            r_last_gnt   <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= (w_state_nxt == S_DONE);
            r_busy       <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_sel_op;
                        r_a        <= w_sel_a;
                        r_n        <= w_sel_n;
                        r_id       <= w_gnt;
                        r_last_gnt <= w_gnt;
                        r_err      <= ~f_legal(w_sel_op);
                        r_acc      <= {WIDTH{1'b0}};
                    end
                end
                S_PASS1: r_acc <= i_sh_o;
                S_PASS2: r_acc <= r_acc | i_sh_o;
                default: r_acc <= r_acc;
            endcase
        end
    end

    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_id    = r_id;
    assign io_bus.resp_data  = r_acc;
    assign io_bus.resp_err   = r_err;
    assign o_busy            = r_busy;

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched: directed cases plus randomized traffic
// checked against an arithmetic reference of the shift operations.
module tb_shift_sched;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [31:0] sh_a, sh_b, sh_o;
    logic        sh_d;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    logic        mdl_busy = 1'b0;
    logic        mdl_last = 1'b1;
    logic        dir_use = 1'b0;
    logic [31:0] dir_data = 32'd0;
    exp_t        sb[$];
    logic        acc_ids[$];

    shift_sched_if bus();

    shift_sched dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus),
        .o_busy (busy),
        .o_sh_a (sh_a),
        .o_sh_b (sh_b),
        .o_sh_d (sh_d),
        .i_sh_o (sh_o)
    );

    assign sh_o = sh_d ? (sh_a >> sh_b) : (sh_a << sh_b);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic id, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          n;
        logic [63:0] dbl;
        n     = int'(b[4:0]);
        dbl   = {a, a};
        e.id  = id;
        e.err = 1'b0;
        e.lat = 2;
        case (op)
            3'd0: e.data = a << n;
            3'd1: e.data = a >> n;
            3'd2: e.data = $unsigned($signed(a) >>> n);
            3'd3: begin dbl = dbl << n; e.data = dbl[63:32]; end
            3'd4: begin dbl = dbl >> n; e.data = dbl[31:0]; end
            default: begin e.data = 32'd0; e.err = 1'b1; end
        endcase
        if (e.err) e.lat = 1;
        else if (n != 0 && ((op == 3'd2 && a[31]) || op == 3'd3 || op == 3'd4)) e.lat = 3;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: response checks against the scoreboard head, then grant checks and pushes.
    always @(negedge clk) begin
        exp_t        h;
        exp_t        e;
        logic [1:0]  exp_rdy;
        logic        g;
        logic        hs;
        if (reset) begin
            sb.delete();
            mdl_busy <= 1'b0;
            mdl_last <= 1'b1;
        end else begin
            hs = 1'b0;
            g  = 1'b0;
            chk("busy", 32'(busy), 32'(mdl_busy));
            if (sb.size() != 0) begin
                h = sb[0];
                chk("resp_valid", 32'(bus.resp_valid), 32'((cyc - h.acc_cyc) >= h.lat));
                if (bus.resp_valid) begin
                    chk("resp_data", bus.resp_data, h.data);
                    chk("resp_id", 32'(bus.resp_id), 32'(h.id));
                    chk("resp_err", 32'(bus.resp_err), 32'(h.err));
                    if (bus.resp_ready) begin
                        void'(sb.pop_front());
                        hs = 1'b1;
                    end
                end
            end else begin
                chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
            end
            exp_rdy = 2'b00;
            if (!mdl_busy && bus.req_valid != 2'b00) begin
                g = (bus.req_valid == 2'b11) ? ~mdl_last : ~bus.req_valid[0];
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (exp_rdy != 2'b00) begin
                if (g) e = ref_op(1'b1, bus.req_op1, bus.req_a1, bus.req_b1);
                else   e = ref_op(1'b0, bus.req_op0, bus.req_a0, bus.req_b0);
                if (dir_use) e.data = dir_data;
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc_ids.push_back(g);
                acc_cnt  <= acc_cnt + 1;
                mdl_last <= g;
                mdl_busy <= 1'b1;
            end else if (hs) begin
                mdl_busy <= 1'b0;
            end else begin
                mdl_busy <= mdl_busy;
            end
        end
    end

    task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (id == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
        else         begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
    endtask

    task automatic wait_accept(input int n0);
        for (int i = 0; i < 50 && acc_cnt == n0; i++) @(posedge clk);
        #1;
        if (acc_cnt == n0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && mdl_busy; i++) begin @(posedge clk); #1; end
        if (mdl_busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_one(input int id, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n0;
        @(posedge clk); #1;
        set_req(id, op, a, b);
        bus.req_valid  = (id == 0) ? 2'b01 : 2'b10;
        bus.resp_ready = (hold == 0);
        dir_use  = 1'b1;
        dir_data = exp;
        n0 = acc_cnt;
        wait_accept(n0);
        dir_use = 1'b0;
        bus.req_valid = (hold > 0) ? 2'b11 : 2'b00;
        if (hold > 0) begin
            for (int i = 0; i < 20 && !bus.resp_valid; i++) begin @(posedge clk); #1; end
            for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
            bus.req_valid  = 2'b00;
            bus.resp_ready = 1'b1;
        end
        wait_idle();
    endtask

    initial begin
        int n0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b1;
        set_req(0, 3'd0, 32'd0, 32'd0);
        set_req(1, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Both requesters held high: grants must alternate starting with 0.
        @(posedge clk); #1;
        set_req(0, 3'd0, 32'h0000_0003, 32'd1);
        set_req(1, 3'd0, 32'h0000_0100, 32'd1);
        bus.req_valid = 2'b11;
        n0 = acc_cnt;
        for (int i = 0; i < 100 && acc_cnt < n0 + 4; i++) @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        chk("rr_count", 32'(acc_cnt - n0 >= 4), 32'd1);
        for (int k = 0; k < 4 && k < acc_ids.size(); k++)
            chk("rr_order", 32'(acc_ids[k]), 32'(k % 2));
        wait_idle();

        run_one(0, 3'd0, 32'h8002_0001, 32'd1,         32'h0004_0002, 0);
        run_one(1, 3'd1, 32'h8002_0001, 32'd1,         32'h4001_0000, 0);
        run_one(1, 3'd2, 32'h8002_0001, 32'd4,         32'hF800_2000, 0);
        run_one(0, 3'd2, 32'h0002_0001, 32'd4,         32'h0000_2000, 0);
        run_one(0, 3'd3, 32'h8002_0001, 32'd4,         32'h0020_0018, 0);
        run_one(1, 3'd4, 32'h8002_0001, 32'd1,         32'hC001_0000, 0);
        run_one(0, 3'd3, 32'h8002_0001, 32'h0008_0000, 32'h8002_0001, 0);
        run_one(1, 3'd7, 32'h1234_5678, 32'd3,         32'h0000_0000, 0);
        run_one(0, 3'd5, 32'hFFFF_FFFF, 32'd2,         32'h0000_0000, 0);
        run_one(0, 3'd0, 32'h0000_FFFF, 32'd8,         32'h00FF_FF00, 5);
        run_one(1, 3'd4, 32'h8002_0001, 32'd31,        32'h0004_0003, 3);

        // Reset while the second pass of a rotate is in progress.
        @(posedge clk); #1;
        set_req(0, 3'd3, 32'h8002_0001, 32'd4);
        bus.req_valid = 2'b01;
        n0 = acc_cnt;
        wait_accept(n0);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        chk("pass2_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        run_one(0, 3'd1, 32'hF000_0000, 32'd4, 32'h0F00_0000, 0);

        // Randomized traffic: operands change every cycle, including while in flight.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            bus.req_valid  = 2'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++)
                set_req(r, 3'($urandom_range(0, 6)), $urandom,
                        ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom);
        end
        @(posedge clk); #1;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b1;
        wait_idle();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Two-requester scheduler for one shared combinational 32-bit shifter, shift_32b (O = D ? A>>B : A<<B, logical).
- Arbitrates requests round-robin and sequences one or two shifter passes per operation.
- Builds SLL/SRL/SRA/ROTL/ROTR from the logical left/right shifter and returns the registered result with a valid/ready handshake.
- Sits between the ALU-side requesters and the shared shifter instance.

Parameters:
- WIDTH, 32, data width; only 32 is supported. Shift amount width is 5.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  one-hot acceptance pulse, combinational, asserted only in IDLE
- req_op0, req_op1  in  3 each  000 SLL, 001 SRL, 010 SRA, 011 ROTL, 100 ROTR, others illegal
- req_a0, req_a1  in  32 each  operand
- req_b0, req_b1  in  32 each  shift amount; only bits [4:0] are used
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester index of the result
- resp_data  out  32  result
- resp_err  out  1  illegal op flag, qualified by resp_valid
- busy  out  1  high in any state other than IDLE
- sh_a  out  32  shifter A input
- sh_b  out  32  shifter B input
- sh_d  out  1  shifter direction: 0 left, 1 right
- sh_o  in  32  shifter output

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- State on reset: state=IDLE, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0, last_gnt=1 (requester 0 wins first).
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - If any req_valid bit is set, grant one requester. If both are set, grant the one != last_gnt.
  - req_ready[g]=1 in this cycle.
  - Latch op, a, n=b[4:0] and id; last_gnt<=g.
  - Next state is PASS1, or DONE with err=1 and data=0 for an illegal op.
- PASS1 drives the shifter per op; acc<=sh_o:
  - SLL: A, n, 0
  - SRL: A, n, 1
  - SRA: A, n, 1
  - ROTL: A, n, 0
  - ROTR: A, n, 1
- Second pass is needed when: (SRA and A[31]=1 and n!=0), or (ROTL/ROTR and n!=0). Otherwise PASS1 goes to DONE.
- PASS2 drives the shifter as follows; acc<=acc|sh_o; next state DONE:
  - SRA: 0xFFFFFFFF, 32-n, 0
  - ROTL: A, 32-n, 1
  - ROTR: A, 32-n, 0
- 32-n is computed in 6 bits and zero-extended onto sh_b; n=0 never reaches PASS2.
- DONE:
  - resp_valid=1; resp_data=acc; resp_id and resp_err held stable.
  - On resp_valid&&resp_ready go to IDLE and drop resp_valid the next cycle.
  - No new request is accepted in DONE, even if resp_ready=1.
- Shifter drive in IDLE and DONE: sh_a=0, sh_b=0, sh_d=0.
- Latency from the acceptance cycle to the first resp_valid cycle:
  - 2 cycles for a single pass, 3 cycles for two passes.
  - 1 cycle for an illegal op.
- Back-to-back: after the DONE handshake, the earliest next acceptance is the following cycle in IDLE.
- Stable operands: request inputs are sampled only at acceptance; later changes have no effect on an op in flight.
- Reset mid-operation: any state returns to IDLE and the in-flight op is discarded with no response.
- A requester whose req_valid drops before it is granted is simply not served.

Test Plan:
- Reset; req0: SLL, A=0x80020001, B=0x00000001, resp_ready=1 → resp_valid 2 cycles after accept; data=0x00040002, id=0, err=0.
- req1: SRL, A=0x80020001, B=1 → 0x40010000. SRA, B=4 → two passes, 0xF8002000 at 3 cycles. SRA with A=0x00020001, B=4 → single pass, 0x00002000.
- ROTL, A=0x80020001, B=4 → 0x00200018 at 3 cycles. ROTR, B=1 → 0xC0010000. ROTL with B=0x00080000 (low bits 0) → single pass, A unchanged.
- Both req_valid high after reset, SLL by 1 on each → requester 0 served first, then requester 1. Keep both high → grants alternate 0,1,0,1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid, resp_data and resp_id stay stable, no req_ready pulses. Release → IDLE the next cycle.
- Illegal op 3'b111 → resp_err=1, data=0, 1 cycle after accept. Assert reset during PASS2 → IDLE, resp_valid=0, busy=0 the next cycle; a new request completes normally afterwards.
